// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared types and constants for the SPI RAM request sequencer
package spi_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [1:0] NBYTES_ONE = 2'd1;
  localparam logic [1:0] NBYTES_TWO = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // Sequential successor of a byte address; wraps 16'hFFFF to 16'h0000.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
    return addr + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/spi_prefetch_buf.sv
// rtl/spi_prefetch_buf.sv - one-entry read prefetch buffer holding the second byte of a read burst
module spi_prefetch_buf
  import spi_mem_pkg::*;
#(
  parameter bit PREFETCH_EN = 1'b1
) (
  input  logic              clk_core_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  logic              pf_valid;
  logic [ADDR_W-1:0] pf_addr;
  logic [DATA_W-1:0] pf_data;

  // load_addr is the address of the first burst byte; the buffered byte sits one above it
  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pf_valid <= 1'b0;
      pf_addr  <= '0;
      pf_data  <= '0;
    end else if (load_en && PREFETCH_EN) begin
      pf_valid <= 1'b1;
      pf_addr  <= next_addr(load_addr);
      pf_data  <= load_data;
    end else if (wr_en && (wr_addr == pf_addr)) begin
      pf_data  <= wr_data;
    end
  end

  assign hit      = pf_valid && (lookup_addr == pf_addr);
  assign hit_data = pf_data;

endmodule

// File: rtl/spi_mem_ctrl.sv
// rtl/spi_mem_ctrl.sv - sequences single-byte core requests into spi_master transactions with read prefetch
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter bit PREFETCH_EN = 1'b1
) (
  input  logic              clk_core_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              spi_start_o,
  output logic [ADDR_W-1:0] spi_addr_o,
  output logic [DATA_W-1:0] spi_wdata_o,
  output logic              spi_rnw_o,
  output logic [1:0]        spi_nbytes_o,
  input  logic [DATA_W-1:0] spi_rdata1_i,
  input  logic [DATA_W-1:0] spi_rdata2_i,
  input  logic              spi_done_i,
  input  logic              spi_busy_i
);

  state_t            state;
  logic              accept;
  logic              pf_hit;
  logic [DATA_W-1:0] pf_data;
  logic              pf_load;

  assign accept  = req_valid_i && req_ready_o;
  assign pf_load = (state == S_WAIT) && spi_done_i && spi_rnw_o;

  spi_prefetch_buf #(
    .PREFETCH_EN (PREFETCH_EN)
  ) u_prefetch_buf (
    .clk_core_i  (clk_core_i),
    .rst_n_i     (rst_n_i),
    .lookup_addr (req_addr_i),
    .hit         (pf_hit),
    .hit_data    (pf_data),
    .wr_en       (accept && req_we_i),
    .wr_addr     (req_addr_i),
    .wr_data     (req_wdata_i),
    .load_en     (pf_load),
    .load_addr   (spi_addr_o),
    .load_data   (spi_rdata2_i)
  );

  // The spi_* request fields double as the registered copy of the accepted request.
  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      req_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      spi_start_o  <= 1'b0;
      spi_addr_o   <= '0;
      spi_wdata_o  <= '0;
      spi_rnw_o    <= 1'b0;
      spi_nbytes_o <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_ready_o <= 1'b0;
            if (!req_we_i && pf_hit) begin
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= pf_data;
              state       <= S_RESP;
            end else begin
              spi_addr_o   <= req_addr_i;
              spi_wdata_o  <= req_we_i ? req_wdata_i : '0;
              spi_rnw_o    <= !req_we_i;
              spi_nbytes_o <= (!req_we_i && PREFETCH_EN) ? NBYTES_TWO : NBYTES_ONE;
              state        <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!spi_busy_i) begin
            spi_start_o <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          spi_start_o <= 1'b0;
          if (spi_done_i) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= spi_rnw_o ? spi_rdata1_i : '0;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid_o <= 1'b0;
          rsp_rdata_o <= '0;
          req_ready_o <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb/tb_spi_mem_ctrl.sv - scoreboard bench for spi_mem_ctrl against a transaction-level SPI RAM
module tb_spi_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        req_valid, req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        spi_busy, spi_done;
  logic [7:0]  spi_rdata1, spi_rdata2;

  logic        ready_a, rsp_valid_a, start_a, rnw_a;
  logic [7:0]  rdata_a, wdata_a;
  logic [15:0] addr_a;
  logic [1:0]  nbytes_a;
  logic        ready_b, rsp_valid_b, start_b, rnw_b;
  logic [7:0]  rdata_b, wdata_b;
  logic [15:0] addr_b;
  logic [1:0]  nbytes_b;

  logic        req_valid_a, req_valid_b;
  assign req_valid_a = req_valid && !sel;
  assign req_valid_b = req_valid && sel;

  logic        ready_m, rsp_valid_m, start_m, rnw_m;
  logic [7:0]  rdata_m, wdata_m;
  logic [15:0] addr_m;
  logic [1:0]  nbytes_m;
  assign ready_m     = sel ? ready_b     : ready_a;
  assign rsp_valid_m = sel ? rsp_valid_b : rsp_valid_a;
  assign start_m     = sel ? start_b     : start_a;
  assign rnw_m       = sel ? rnw_b       : rnw_a;
  assign rdata_m     = sel ? rdata_b     : rdata_a;
  assign wdata_m     = sel ? wdata_b     : wdata_a;
  assign addr_m      = sel ? addr_b      : addr_a;
  assign nbytes_m    = sel ? nbytes_b    : nbytes_a;

  spi_mem_ctrl #(.PREFETCH_EN(1'b1)) u_dut_pf (
    .clk_core_i (clk), .rst_n_i (rst_n),
    .req_valid_i (req_valid_a), .req_ready_o (ready_a), .req_we_i (req_we),
    .req_addr_i (req_addr), .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid_a), .rsp_rdata_o (rdata_a),
    .spi_start_o (start_a), .spi_addr_o (addr_a), .spi_wdata_o (wdata_a),
    .spi_rnw_o (rnw_a), .spi_nbytes_o (nbytes_a),
    .spi_rdata1_i (spi_rdata1), .spi_rdata2_i (spi_rdata2),
    .spi_done_i (spi_done), .spi_busy_i (spi_busy)
  );

  spi_mem_ctrl #(.PREFETCH_EN(1'b0)) u_dut_nopf (
    .clk_core_i (clk), .rst_n_i (rst_n),
    .req_valid_i (req_valid_b), .req_ready_o (ready_b), .req_we_i (req_we),
    .req_addr_i (req_addr), .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid_b), .rsp_rdata_o (rdata_b),
    .spi_start_o (start_b), .spi_addr_o (addr_b), .spi_wdata_o (wdata_b),
    .spi_rnw_o (rnw_b), .spi_nbytes_o (nbytes_b),
    .spi_rdata1_i (spi_rdata1), .spi_rdata2_i (spi_rdata2),
    .spi_done_i (spi_done), .spi_busy_i (spi_busy)
  );

  int n_cmp = 0, n_fail = 0, n_starts = 0, n_rsp = 0;
  bit stray_req = 1'b0;

  logic [7:0]  ram     [0:65535];
  logic [7:0]  mdl_mem [0:65535];
  bit          mdl_pf_v;
  logic [15:0] mdl_pf_tag;

  typedef struct {
    logic [7:0] data;
    bit         hit;
    time        acc_t;
    int         starts0;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // SPI side: a transaction-level stand-in for spi_master plus the external RAM
  initial begin
    int lat, tail;
    bit active;
    logic [15:0] a;
    logic [7:0]  wd;
    logic        rnw;
    logic [1:0]  nb;
    lat = 0; tail = 0; active = 1'b0; a = '0; wd = '0; rnw = 1'b0; nb = '0;
    spi_busy = 1'b0; spi_done = 1'b0; spi_rdata1 = '0; spi_rdata2 = '0;
    forever begin
      @(posedge clk); #1;
      spi_done = 1'b0;
      if (!rst_n) begin
        active = 1'b0; tail = 0; spi_busy = 1'b0;
      end else if (start_m) begin
        chk("start_while_busy", spi_busy, 0);
        chk("spi_nbytes", nbytes_m, (rnw_m && !sel) ? 2 : 1);
        n_starts++;
        a = addr_m; wd = wdata_m; rnw = rnw_m; nb = nbytes_m;
        lat = $urandom_range(1, 5); active = 1'b1; tail = 0; spi_busy = 1'b1;
      end else if (active) begin
        if (lat > 1) lat--;
        else begin
          chk("spi_fields_stable", {addr_m, rnw_m, nbytes_m, wdata_m}, {a, rnw, nb, wd});
          if (rnw) begin
            spi_rdata1 = ram[a];
            spi_rdata2 = (nb == 2'd2) ? ram[a + 16'd1] : 8'($urandom);
          end else begin
            ram[a] = wd;
          end
          spi_done = 1'b1; active = 1'b0;
          tail = $urandom_range(0, 3);
          if (tail == 0) spi_busy = 1'b0;
        end
      end else if (tail > 0) begin
        tail--;
        if (tail == 0) spi_busy = 1'b0;
      end else if (stray_req) begin
        stray_req = 1'b0;
        spi_rdata1 = 8'($urandom); spi_rdata2 = 8'($urandom);
        spi_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (sel ? (rsp_valid_a || start_a) : (rsp_valid_b || start_b))
        chk("idle_instance_quiet", 1, 0);
      if (rsp_valid_m) begin
        n_rsp++;
        if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rdata_m, e.data);
          chk("rsp_spi_starts", n_starts - e.starts0, e.hit ? 0 : 1);
          if (e.hit) chk("hit_latency", $time - e.acc_t, 5);
        end
      end
    end
  end

  task automatic issue_req(input bit we, input logic [15:0] addr, input logic [7:0] wd);
    exp_t e;
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    t = 0;
    while (!ready_m && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("accept_timeout", 1, 0);
    e.acc_t = $time + 5; e.starts0 = n_starts; e.hit = 1'b0;
    if (we) begin
      mdl_mem[addr] = wd;
      e.data = 8'h00;
    end else begin
      e.hit  = !sel && mdl_pf_v && (mdl_pf_tag == addr);
      e.data = mdl_mem[addr];
      if (!sel && !e.hit) begin mdl_pf_v = 1'b1; mdl_pf_tag = addr + 16'd1; end
    end
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(negedge clk); t++; end
    chk("rsp_timeout", exp_q.size(), 0);
  endtask

  task automatic do_req(input bit we, input logic [15:0] addr, input logic [7:0] wd);
    issue_req(we, addr, wd);
    wait_rsp();
  endtask

  task automatic preload(input logic [15:0] addr, input logic [7:0] d);
    ram[addr] = d; mdl_mem[addr] = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_reset_a"}, {ready_a, rsp_valid_a, start_a, rnw_a, nbytes_a, rdata_a, wdata_a, addr_a}, {1'b1, 37'd0});
    chk({tag, "_reset_b"}, {ready_b, rsp_valid_b, start_b, rnw_b, nbytes_b, rdata_b, wdata_b, addr_b}, {1'b1, 37'd0});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int s0, r0, t;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'($urandom);
      mdl_mem[i] = ram[i];
    end
    sel = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mdl_pf_v = 1'b0; mdl_pf_tag = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("init");
    rst_n = 1'b1;

    s0 = n_starts;
    do_req(1'b1, 16'h0010, 8'hA5);
    do_req(1'b0, 16'h0010, 8'h00);
    chk("wr_rd_starts", n_starts - s0, 2);

    preload(16'h0020, 8'h11); preload(16'h0021, 8'h22);
    s0 = n_starts;
    do_req(1'b0, 16'h0020, 8'h00);
    do_req(1'b0, 16'h0021, 8'h00);
    chk("seq_hit_starts", n_starts - s0, 1);

    s0 = n_starts;
    do_req(1'b0, 16'h0020, 8'h00);
    do_req(1'b1, 16'h0021, 8'h77);
    do_req(1'b0, 16'h0021, 8'h00);
    chk("coherence_starts", n_starts - s0, 2);

    preload(16'hFFFF, 8'h01); preload(16'h0000, 8'h02);
    s0 = n_starts;
    do_req(1'b0, 16'hFFFF, 8'h00);
    do_req(1'b0, 16'h0000, 8'h00);
    chk("wrap_starts", n_starts - s0, 1);

    s0 = n_starts;
    issue_req(1'b0, 16'h0030, 8'h00);
    t = 0;
    while (n_starts == s0 && t < 100) begin @(negedge clk); t++; end
    chk("abort_start_seen", n_starts - s0, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    exp_q.delete();
    mdl_pf_v = 1'b0;
    r0 = n_rsp;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_rsp", n_rsp, r0);
    s0 = n_starts;
    do_req(1'b0, 16'h0031, 8'h00);
    chk("miss_after_abort", n_starts - s0, 1);

    stray_req = 1'b1;
    repeat (10) @(negedge clk);
    chk("stray_done_sent", stray_req, 0);
    s0 = n_starts;
    do_req(1'b0, 16'h0032, 8'h00);
    chk("hit_after_stray_done", n_starts - s0, 0);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0: a = 16'hFFFF;
        1: a = 16'h0000;
        default: a = 16'h0040 + 16'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 9) == 0) stray_req = 1'b1;
      do_req($urandom_range(0, 3) == 0, a, 8'($urandom));
    end

    repeat (5) @(negedge clk);
    sel = 1'b1;
    preload(16'h0050, 8'h3C); preload(16'h0051, 8'hC3);
    s0 = n_starts;
    do_req(1'b0, 16'h0050, 8'h00);
    do_req(1'b0, 16'h0051, 8'h00);
    chk("nopf_starts", n_starts - s0, 2);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
